// File: rtl/dpa_pkg.sv
// rtl/dpa_pkg.sv - shared constants and types for the DPA image-memory path
//
// Purpose: IM bus widths, requester identity and arbiter state encoding,
// shared by the image-memory arbiter and its picker.
// Ports: none (package).
package dpa_pkg;

  localparam int   AW          = 20;    // IM address width
  localparam int   DW          = 24;    // IM data width (RGB888)
  localparam logic IM_WEN_IDLE = 1'b1;  // im_wen_n level when nothing is issued

  typedef enum logic {
    OWN_P = 1'b0,  // photo-copy engine
    OWN_T = 1'b1   // time-overlay writer
  } owner_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_P = 2'd1,
    GNT_T = 2'd2
  } arb_state_e;

endpackage

// File: rtl/im_arbiter_if.sv
// rtl/im_arbiter_if.sv - requester and IM pin bundle for the image-memory arbiter
//
// Purpose: groups both requester handshakes and the IM pins.
// Ports (signals):
//   P side : req_p, we_p, addr_p, wdata_p, last_p -> arbiter; gnt_p, rvalid_p <- arbiter
//   T side : req_t, we_t, addr_t, wdata_t, last_t -> arbiter; gnt_t, rvalid_t <- arbiter
//   shared : rdata <- arbiter
//   IM pins: im_a, im_wen_n, im_d <- arbiter; im_q -> arbiter
// Modports: slave = arbiter side, master = requesters plus memory side.
interface im_arbiter_if #(
  parameter int AW = dpa_pkg::AW,
  parameter int DW = dpa_pkg::DW
);
  import dpa_pkg::*;

  logic          req_p;
  logic          we_p;
  logic [AW-1:0] addr_p;
  logic [DW-1:0] wdata_p;
  logic          last_p;
  logic          gnt_p;
  logic          rvalid_p;

  logic          req_t;
  logic          we_t;
  logic [AW-1:0] addr_t;
  logic [DW-1:0] wdata_t;
  logic          last_t;
  logic          gnt_t;
  logic          rvalid_t;

  logic [DW-1:0] rdata;

  logic [AW-1:0] im_a;
  logic          im_wen_n;
  logic [DW-1:0] im_d;
  logic [DW-1:0] im_q;

  modport slave (
    input  req_p, we_p, addr_p, wdata_p, last_p,
    input  req_t, we_t, addr_t, wdata_t, last_t,
    input  im_q,
    output gnt_p, rvalid_p, gnt_t, rvalid_t, rdata,
    output im_a, im_wen_n, im_d
  );

  modport master (
    output req_p, we_p, addr_p, wdata_p, last_p,
    output req_t, we_t, addr_t, wdata_t, last_t,
    output im_q,
    input  gnt_p, rvalid_p, gnt_t, rvalid_t, rdata,
    input  im_a, im_wen_n, im_d
  );

endinterface

// File: rtl/im_arb_rr.sv
// rtl/im_arb_rr.sv - 2-way round-robin picker for the image-memory arbiter
//
// Purpose: chooses which requester to grant next. On a tie the requester
// that did not own the memory last wins. Purely combinational.
// Ports:
//   i_req_p, i_req_t : candidate requests
//   i_last_owner     : requester that released ownership most recently
//   o_pick           : chosen requester (meaningful only if a request is high)
module im_arb_rr
  import dpa_pkg::*;
(
  input  logic   i_req_p,
  input  logic   i_req_t,
  input  owner_e i_last_owner,
  output owner_e o_pick
);

  always_comb begin
    o_pick = OWN_P;
    if (i_req_p && i_req_t) begin
      o_pick = (i_last_owner == OWN_P) ? OWN_T : OWN_P;
    end else if (i_req_t) begin
      o_pick = OWN_T;
    end
  end

endmodule

// File: rtl/im_arbiter.sv
// rtl/im_arbiter.sv - burst-granting round-robin arbiter for the single-port IM
//
// Purpose: shares the image memory between the photo-copy engine (P) and the
// time-overlay writer (T). Whole bursts are granted, capped at MAX_BURST
// transfers; IM pins are registered; read data is routed back by a tag pipe.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-low reset
//   bus   : im_arbiter_if.slave (requester handshakes, rdata, IM pins)
module im_arbiter #(
  parameter int AW        = dpa_pkg::AW,
  parameter int DW        = dpa_pkg::DW,
  parameter int MAX_BURST = 16
) (
  input logic         clk,
  input logic         reset,
  im_arbiter_if.slave bus
);
  import dpa_pkg::*;

  localparam logic [7:0] CAP_M1 = 8'(MAX_BURST - 1);

  arb_state_e    r_state;
  logic          r_gnt_p;
  logic          r_gnt_t;
  owner_e        r_last_owner;
  logic [7:0]    r_burst_cnt;

  logic [AW-1:0] r_im_a;
  logic [DW-1:0] r_im_d;
  logic          r_im_wen_n;

  logic          r_tag1_vld;
  owner_e        r_tag1_own;
  logic          r_rvalid_p;
  logic          r_rvalid_t;
  logic [DW-1:0] r_rdata;

  logic          w_xfer_p;
  logic          w_xfer_t;
  logic          w_xfer;
  owner_e        w_cur;
  logic          w_last_x;
  logic          w_release;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;
  logic          w_we;
  logic          w_rr_req_p;
  logic          w_rr_req_t;
  owner_e        w_rr_last;
  owner_e        w_pick;
  logic          w_any;
  arb_state_e    w_pick_state;

  assign w_xfer_p = bus.req_p & r_gnt_p;
  assign w_xfer_t = bus.req_t & r_gnt_t;
  assign w_xfer   = w_xfer_p | w_xfer_t;

  // Only the current owner's signals are ever looked at.
  assign w_cur    = r_gnt_t ? OWN_T : OWN_P;
  assign w_last_x = r_gnt_t ? bus.last_t  : bus.last_p;
  assign w_addr   = r_gnt_t ? bus.addr_t  : bus.addr_p;
  assign w_wdata  = r_gnt_t ? bus.wdata_t : bus.wdata_p;
  assign w_we     = r_gnt_t ? bus.we_t    : bus.we_p;

  assign w_release = w_xfer & (w_last_x | (r_burst_cnt == CAP_M1));

  // The same picker serves IDLE and the handoff: the owner's own request is
  // masked so that a release always hands over to the other side or idles.
  assign w_rr_req_p = bus.req_p & ~r_gnt_p;
  assign w_rr_req_t = bus.req_t & ~r_gnt_t;
  assign w_rr_last  = (r_state == IDLE) ? r_last_owner : w_cur;
  assign w_any      = w_rr_req_p | w_rr_req_t;

  im_arb_rr u_rr (
    .i_req_p      (w_rr_req_p),
    .i_req_t      (w_rr_req_t),
    .i_last_owner (w_rr_last),
    .o_pick       (w_pick)
  );

  assign w_pick_state = !w_any            ? IDLE  :
                        (w_pick == OWN_T) ? GNT_T : GNT_P;

  // Ownership FSM; grants are registered alongside the state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_gnt_p      <= 1'b0;
      r_gnt_t      <= 1'b0;
      r_last_owner <= OWN_P;
      r_burst_cnt  <= 8'd0;
    end else begin
      case (r_state)
        IDLE: begin
          r_state <= w_pick_state;
          r_gnt_p <= (w_pick_state == GNT_P);
          r_gnt_t <= (w_pick_state == GNT_T);
        end
        GNT_P, GNT_T: begin
          if (w_release) begin
            r_burst_cnt  <= 8'd0;
            r_last_owner <= w_cur;
            r_state      <= w_pick_state;
            r_gnt_p      <= (w_pick_state == GNT_P);
            r_gnt_t      <= (w_pick_state == GNT_T);
          end else if (w_xfer) begin
            r_burst_cnt <= r_burst_cnt + 8'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_gnt_p <= 1'b0;
          r_gnt_t <= 1'b0;
        end
      endcase
    end
  end

  // Issue path: address/data hold between transfers, only wen returns idle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_im_a     <= '0;
      r_im_d     <= '0;
      r_im_wen_n <= IM_WEN_IDLE;
    end else if (w_xfer) begin
      r_im_a     <= w_addr;
      r_im_d     <= w_wdata;
      r_im_wen_n <= ~w_we;
    end else begin
      r_im_wen_n <= IM_WEN_IDLE;
    end
  end

  // Return path: the issuer's identity travels with the read so the data is
  // routed correctly even after ownership has moved on.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_tag1_vld <= 1'b0;
      r_tag1_own <= OWN_P;
      r_rvalid_p <= 1'b0;
      r_rvalid_t <= 1'b0;
      r_rdata    <= '0;
    end else begin
      r_tag1_vld <= w_xfer & ~w_we;
      r_tag1_own <= w_cur;
      r_rvalid_p <= r_tag1_vld & (r_tag1_own == OWN_P);
      r_rvalid_t <= r_tag1_vld & (r_tag1_own == OWN_T);
      if (r_tag1_vld) begin
        r_rdata <= bus.im_q;
      end
    end
  end

  assign bus.gnt_p    = r_gnt_p;
  assign bus.gnt_t    = r_gnt_t;
  assign bus.rvalid_p = r_rvalid_p;
  assign bus.rvalid_t = r_rvalid_t;
  assign bus.rdata    = r_rdata;
  assign bus.im_a     = r_im_a;
  assign bus.im_d     = r_im_d;
  assign bus.im_wen_n = r_im_wen_n;

endmodule

// File: tb/tb_im_arbiter.sv
// tb/tb_im_arbiter.sv - self-checking bench for im_arbiter
module tb_im_arbiter;
  import dpa_pkg::*;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          we;
    int            due;
  } iss_t;

  typedef struct {
    logic          own;
    logic [DW-1:0] d;
    int            due;
  } rd_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   rv_p_cnt = 0;
  int   rv_t_cnt = 0;
  bit   mon_en = 1'b0;
  iss_t iq[$];
  rd_t  rq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  im_arbiter_if bus ();

  im_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
    return {a[11:0] ^ 12'hA5C, a[19:8]};
  endfunction

  // Asynchronous-read memory model: IM data follows the presented address.
  assign bus.im_q = mem_val(bus.im_a);

  // Push the expected IM issue / read return for any transfer happening at
  // the coming edge, then advance one cycle. Reset squashes future work.
  task automatic tick();
    iss_t e;
    rd_t  r;
    if (reset) begin
      if (bus.req_p && bus.gnt_p) begin
        e.a = bus.addr_p; e.d = bus.wdata_p; e.we = bus.we_p; e.due = cyc + 1;
        iq.push_back(e);
        if (!bus.we_p) begin
          r.own = 1'b0; r.d = mem_val(bus.addr_p); r.due = cyc + 2;
          rq.push_back(r);
        end
      end
      if (bus.req_t && bus.gnt_t) begin
        e.a = bus.addr_t; e.d = bus.wdata_t; e.we = bus.we_t; e.due = cyc + 1;
        iq.push_back(e);
        if (!bus.we_t) begin
          r.own = 1'b1; r.d = mem_val(bus.addr_t); r.due = cyc + 2;
          rq.push_back(r);
        end
      end
    end else begin
      for (int i = iq.size() - 1; i >= 0; i--) if (iq[i].due > cyc) iq.delete(i);
      for (int i = rq.size() - 1; i >= 0; i--) if (rq[i].due > cyc) rq.delete(i);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt_p();
    int w = 0;
    while (bus.gnt_p !== 1'b1 && w < 4) begin
      tick();
      w++;
    end
    n_cmp++;
    if (bus.gnt_p !== 1'b1) begin
      n_err++;
      $display("FAIL gnt_p_timeout: gnt_p=%b required 1", bus.gnt_p);
    end
  endtask

  // Scoreboard monitor, sampled mid-cycle.
  always begin
    iss_t e;
    rd_t  r;
    @(posedge clk);
    #2;
    if (mon_en) begin
      n_cmp++;
      if (iq.size() > 0 && iq[0].due == cyc) begin
        e = iq.pop_front();
        if (bus.im_wen_n !== ~e.we || bus.im_a !== e.a || (e.we && bus.im_d !== e.d)) begin
          n_err++;
          $display("FAIL issue cyc=%0d: im_a=%h im_wen_n=%b im_d=%h required im_a=%h im_wen_n=%b im_d=%h",
                   cyc, bus.im_a, bus.im_wen_n, bus.im_d, e.a, ~e.we, e.d);
        end
      end else if (bus.im_wen_n !== 1'b1) begin
        n_err++;
        $display("FAIL idle_wen cyc=%0d: im_wen_n=%b required 1", cyc, bus.im_wen_n);
      end

      if (bus.rvalid_p === 1'b1) rv_p_cnt++;
      if (bus.rvalid_t === 1'b1) rv_t_cnt++;
      if (bus.rvalid_p !== 1'b0 || bus.rvalid_t !== 1'b0) begin
        n_cmp++;
        if (rq.size() > 0 && rq[0].due == cyc) begin
          r = rq.pop_front();
          if (bus.rvalid_p !== ~r.own || bus.rvalid_t !== r.own || bus.rdata !== r.d) begin
            n_err++;
            $display("FAIL read_return cyc=%0d: rvalid_p=%b rvalid_t=%b rdata=%h required rvalid_p=%b rvalid_t=%b rdata=%h",
                     cyc, bus.rvalid_p, bus.rvalid_t, bus.rdata, ~r.own, r.own, r.d);
          end
        end else begin
          n_err++;
          $display("FAIL unexpected_rvalid cyc=%0d: rvalid_p=%b rvalid_t=%b required 0 0",
                   cyc, bus.rvalid_p, bus.rvalid_t);
        end
      end else if (rq.size() > 0 && rq[0].due == cyc) begin
        r = rq.pop_front();
        n_cmp++;
        n_err++;
        $display("FAIL missing_rvalid cyc=%0d: rvalid_p=0 rvalid_t=0 required owner=%b data=%h",
                 cyc, r.own, r.d);
      end

      n_cmp++;
      if (bus.gnt_p === 1'b1 && bus.gnt_t === 1'b1) begin
        n_err++;
        $display("FAIL dual_grant cyc=%0d: gnt_p=1 gnt_t=1 required at most one", cyc);
      end
    end
  end

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    n_cmp++; if (bus.gnt_p !== 1'b0) begin n_err++; $display("FAIL reset_gnt_p: %b required 0", bus.gnt_p); end
    n_cmp++; if (bus.gnt_t !== 1'b0) begin n_err++; $display("FAIL reset_gnt_t: %b required 0", bus.gnt_t); end
    n_cmp++; if (bus.rvalid_p !== 1'b0 || bus.rvalid_t !== 1'b0) begin
      n_err++; $display("FAIL reset_rvalid: %b%b required 00", bus.rvalid_p, bus.rvalid_t); end
    n_cmp++; if (bus.im_a !== '0) begin n_err++; $display("FAIL reset_im_a: %h required 0", bus.im_a); end
    n_cmp++; if (bus.im_d !== '0) begin n_err++; $display("FAIL reset_im_d: %h required 0", bus.im_d); end
    n_cmp++; if (bus.im_wen_n !== 1'b1) begin n_err++; $display("FAIL reset_wen: %b required 1", bus.im_wen_n); end
    mon_en = 1'b1;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_t_write_burst();
    bus.req_t = 1'b1; bus.we_t = 1'b1; bus.last_t = 1'b0;
    bus.addr_t = 20'h00100; bus.wdata_t = 24'h111000;
    tick();
    for (int i = 0; i < 3; i++) begin
      bus.addr_t  = 20'h00100 + 20'(i);
      bus.wdata_t = 24'h111000 + 24'(i);
      bus.last_t  = (i == 2);
      n_cmp++;
      if (bus.gnt_t !== 1'b1 || bus.gnt_p !== 1'b0) begin
        n_err++; $display("FAIL t_burst_gnt[%0d]: gnt_t=%b gnt_p=%b required 1 0", i, bus.gnt_t, bus.gnt_p);
      end
      tick();
    end
    bus.req_t = 1'b0; bus.last_t = 1'b0;
    n_cmp++; if (bus.gnt_t !== 1'b0) begin n_err++; $display("FAIL t_burst_release: gnt_t=%b required 0", bus.gnt_t); end
    tick();
    tick();
    n_cmp++; if (bus.im_a !== 20'h00102) begin n_err++; $display("FAIL t_burst_hold_a: im_a=%h required 00102", bus.im_a); end
  endtask

  task automatic test_tie();
    reset = 1'b0; tick(); tick(); reset = 1'b1;
    bus.req_p = 1'b1; bus.we_p = 1'b1; bus.addr_p = 20'h00200; bus.wdata_p = 24'hAA0000; bus.last_p = 1'b0;
    bus.req_t = 1'b1; bus.we_t = 1'b1; bus.addr_t = 20'h00300; bus.wdata_t = 24'hBB0000; bus.last_t = 1'b0;
    tick();
    n_cmp++; if (bus.gnt_t !== 1'b1 || bus.gnt_p !== 1'b0) begin
      n_err++; $display("FAIL tie_first: gnt_t=%b gnt_p=%b required 1 0", bus.gnt_t, bus.gnt_p); end
    tick();
    bus.addr_t = 20'h00301; bus.wdata_t = 24'hBB0001; bus.last_t = 1'b1;
    tick();
    n_cmp++; if (bus.gnt_p !== 1'b1 || bus.gnt_t !== 1'b0) begin
      n_err++; $display("FAIL handoff_no_bubble: gnt_p=%b gnt_t=%b required 1 0", bus.gnt_p, bus.gnt_t); end
    bus.req_t = 1'b0; bus.last_t = 1'b0;
    tick();
    bus.addr_p = 20'h00201; bus.wdata_p = 24'hAA0001; bus.last_p = 1'b1;
    tick();
    bus.req_p = 1'b0; bus.last_p = 1'b0;
    n_cmp++; if (bus.gnt_p !== 1'b0 || bus.gnt_t !== 1'b0) begin
      n_err++; $display("FAIL tie_idle: gnt_p=%b gnt_t=%b required 0 0", bus.gnt_p, bus.gnt_t); end
    tick();
    tick();
    bus.req_p = 1'b1; bus.addr_p = 20'h00210; bus.last_p = 1'b1;
    bus.req_t = 1'b1; bus.addr_t = 20'h00310; bus.last_t = 1'b1;
    tick();
    n_cmp++; if (bus.gnt_t !== 1'b1 || bus.gnt_p !== 1'b0) begin
      n_err++; $display("FAIL tie_second: gnt_t=%b gnt_p=%b required 1 0", bus.gnt_t, bus.gnt_p); end
    tick();
    bus.req_t = 1'b0; bus.last_t = 1'b0;
    n_cmp++; if (bus.gnt_p !== 1'b1) begin n_err++; $display("FAIL tie_handoff_p: gnt_p=%b required 1", bus.gnt_p); end
    tick();
    bus.req_p = 1'b0; bus.last_p = 1'b0;
    tick();
  endtask

  task automatic test_cap_read();
    int rv0 = rv_p_cnt;
    bus.req_p = 1'b1; bus.we_p = 1'b0; bus.last_p = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus.addr_p = 20'h00400 + 20'(i);
      bus.last_p = (i == 19);
      wait_gnt_p();
      tick();
      if (i == 15) begin
        n_cmp++;
        if (bus.gnt_p !== 1'b0) begin n_err++; $display("FAIL cap_release: gnt_p=%b required 0", bus.gnt_p); end
      end
    end
    bus.req_p = 1'b0; bus.last_p = 1'b0;
    n_cmp++; if (bus.gnt_p !== 1'b0) begin n_err++; $display("FAIL cap_last_release: gnt_p=%b required 0", bus.gnt_p); end
    tick(); tick(); tick();
    n_cmp++; if (rv_p_cnt - rv0 != 20) begin
      n_err++; $display("FAIL cap_rvalid_count: %0d required 20", rv_p_cnt - rv0); end
    n_cmp++; if (rq.size() != 0) begin n_err++; $display("FAIL cap_pending: %0d required 0", rq.size()); end
  endtask

  task automatic test_read_handoff();
    bus.req_p = 1'b1; bus.we_p = 1'b0; bus.addr_p = 20'h0ABCD; bus.last_p = 1'b1;
    wait_gnt_p();
    bus.req_t = 1'b1; bus.we_t = 1'b1; bus.addr_t = 20'h00555; bus.wdata_t = 24'h0C0FFE; bus.last_t = 1'b1;
    tick();
    n_cmp++; if (bus.gnt_t !== 1'b1 || bus.gnt_p !== 1'b0) begin
      n_err++; $display("FAIL rh_handoff: gnt_t=%b gnt_p=%b required 1 0", bus.gnt_t, bus.gnt_p); end
    bus.req_p = 1'b0; bus.last_p = 1'b0;
    tick();
    bus.req_t = 1'b0; bus.last_t = 1'b0;
    n_cmp++; if (bus.rvalid_p !== 1'b1 || bus.rvalid_t !== 1'b0 || bus.rdata !== mem_val(20'h0ABCD)) begin
      n_err++; $display("FAIL rh_route: rvalid_p=%b rvalid_t=%b rdata=%h required 1 0 %h",
                        bus.rvalid_p, bus.rvalid_t, bus.rdata, mem_val(20'h0ABCD)); end
    tick();
  endtask

  task automatic test_hold();
    bus.req_p = 1'b1; bus.we_p = 1'b1; bus.last_p = 1'b0;
    bus.addr_p = 20'h00600; bus.wdata_p = 24'h600000;
    wait_gnt_p();
    for (int i = 0; i < 2; i++) begin
      bus.addr_p = 20'h00600 + 20'(i); bus.wdata_p = 24'h600000 + 24'(i);
      tick();
    end
    bus.req_p = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (bus.gnt_p !== 1'b1) begin n_err++; $display("FAIL hold_gnt[%0d]: gnt_p=%b required 1", i, bus.gnt_p); end
      n_cmp++; if (bus.im_a !== 20'h00601) begin n_err++; $display("FAIL hold_im_a[%0d]: im_a=%h required 00601", i, bus.im_a); end
      tick();
    end
    bus.req_p = 1'b1;
    for (int i = 2; i < 16; i++) begin
      bus.addr_p = 20'h00600 + 20'(i); bus.wdata_p = 24'h600000 + 24'(i);
      if (i == 15) begin
        bus.last_p = 1'b1;
        bus.req_t = 1'b1; bus.we_t = 1'b1; bus.addr_t = 20'h00700; bus.wdata_t = 24'h700000; bus.last_t = 1'b1;
      end
      n_cmp++; if (bus.gnt_p !== 1'b1) begin n_err++; $display("FAIL hold_resume[%0d]: gnt_p=%b required 1", i, bus.gnt_p); end
      tick();
    end
    bus.req_p = 1'b0; bus.last_p = 1'b0;
    n_cmp++; if (bus.gnt_t !== 1'b1 || bus.gnt_p !== 1'b0) begin
      n_err++; $display("FAIL cap_and_last: gnt_t=%b gnt_p=%b required 1 0", bus.gnt_t, bus.gnt_p); end
    tick();
    bus.req_t = 1'b0; bus.last_t = 1'b0;
    n_cmp++; if (bus.gnt_t !== 1'b0 || bus.gnt_p !== 1'b0) begin
      n_err++; $display("FAIL hold_end_idle: gnt_t=%b gnt_p=%b required 0 0", bus.gnt_t, bus.gnt_p); end
    tick();
  endtask

  task automatic test_reset_mid();
    bus.req_p = 1'b1; bus.we_p = 1'b0; bus.addr_p = 20'h00333; bus.last_p = 1'b0;
    wait_gnt_p();
    tick();
    reset = 1'b0; bus.req_p = 1'b0;
    tick();
    n_cmp++; if (bus.gnt_p !== 1'b0 || bus.gnt_t !== 1'b0) begin
      n_err++; $display("FAIL rst_mid_gnt: gnt_p=%b gnt_t=%b required 0 0", bus.gnt_p, bus.gnt_t); end
    n_cmp++; if (bus.im_wen_n !== 1'b1) begin n_err++; $display("FAIL rst_mid_wen: %b required 1", bus.im_wen_n); end
    n_cmp++; if (bus.im_a !== '0) begin n_err++; $display("FAIL rst_mid_im_a: %h required 0", bus.im_a); end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (bus.rvalid_p !== 1'b0 || bus.rvalid_t !== 1'b0) begin
        n_err++; $display("FAIL rst_mid_rvalid[%0d]: %b%b required 00", i, bus.rvalid_p, bus.rvalid_t); end
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_p = 1'b0; bus.we_p = 1'b0; bus.addr_p = '0; bus.wdata_p = '0; bus.last_p = 1'b0;
    bus.req_t = 1'b0; bus.we_t = 1'b0; bus.addr_t = '0; bus.wdata_t = '0; bus.last_t = 1'b0;
    test_reset();
    test_t_write_burst();
    test_tie();
    test_cap_read();
    test_read_handoff();
    test_hold();
    test_reset_mid();
    tick();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
